// File: rtl/noc_pkg.sv
// Shared router constants and port naming for the 5-port wormhole NoC.
// Every module in the router slice imports this package.
package noc_pkg;

  localparam int N_PORTS   = 5;
  localparam int BUF_DEPTH = 4;
  localparam int PORT_W    = $clog2(N_PORTS);
  localparam int CRED_W    = $clog2(BUF_DEPTH + 1);

  typedef enum logic [PORT_W-1:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first request at or after ptr wins.
// The search wraps from the last port back to port 0.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]  idx,
  output logic               found
);

  always_comb begin
    int j;
    logic [PORT_W-1:0] jj;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      j = int'(ptr) + k;
      if (j >= N_PORTS) j = j - N_PORTS;
      jj = PORT_W'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        idx     = jj;
        gnt[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Output-port allocator for the wormhole router: per-output round-robin,
// head-to-tail locking and downstream credit tracking.
module switch_allocator
  import noc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_i,
  input  logic [N_PORTS*PORT_W-1:0]   req_dest_i,
  input  logic [N_PORTS-1:0]          head_i,
  input  logic [N_PORTS-1:0]          tail_i,
  input  logic [N_PORTS-1:0]          credit_i,
  output logic [N_PORTS-1:0]          grant_o,
  output logic [N_PORTS-1:0]          xbar_v_o,
  output logic [N_PORTS*PORT_W-1:0]   xbar_sel_o,
  output logic                        err_o
);

  logic [N_PORTS-1:0] lock_v;
  logic [PORT_W-1:0]  lock_own [N_PORTS];
  logic [PORT_W-1:0]  rr_ptr   [N_PORTS];
  logic [CRED_W-1:0]  cred     [N_PORTS];

  logic [PORT_W-1:0]  dest     [N_PORTS];
  logic [N_PORTS-1:0] req_ok;
  logic [N_PORTS-1:0] cand     [N_PORTS];
  logic [N_PORTS-1:0] arb_gnt  [N_PORTS];
  logic [PORT_W-1:0]  arb_idx  [N_PORTS];
  logic               arb_found[N_PORTS];

  logic [N_PORTS-1:0] out_v;
  logic [PORT_W-1:0]  out_idx  [N_PORTS];
  logic [N_PORTS-1:0] out_gnt  [N_PORTS];
  logic               err_set;

  // Out-of-range destinations are dropped here so no output ever sees them.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dest[i]   = req_dest_i[i*PORT_W +: PORT_W];
      req_ok[i] = req_i[i] && (dest[i] < PORT_W'(N_PORTS));
    end
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        cand[o][i] = req_ok[i] && head_i[i] && (dest[i] == PORT_W'(o));
      end
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    rr_arbiter u_arb (
      .req   (cand[o]),
      .ptr   (rr_ptr[o]),
      .gnt   (arb_gnt[o]),
      .idx   (arb_idx[o]),
      .found (arb_found[o])
    );
  end

  // A locked output only listens to its owner's body/tail flits.
  always_comb begin
    logic [PORT_W-1:0] own;
    own        = '0;
    out_v      = '0;
    grant_o    = '0;
    xbar_v_o   = '0;
    xbar_sel_o = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      out_idx[o] = '0;
      out_gnt[o] = '0;
      if (rst && (cred[o] != '0)) begin
        if (lock_v[o]) begin
          own = lock_own[o];
          if (req_ok[own] && !head_i[own] && (dest[own] == PORT_W'(o))) begin
            out_v[o]        = 1'b1;
            out_idx[o]      = own;
            out_gnt[o][own] = 1'b1;
          end
        end else if (arb_found[o]) begin
          out_v[o]   = 1'b1;
          out_idx[o] = arb_idx[o];
          out_gnt[o] = arb_gnt[o];
        end
      end
      grant_o                         = grant_o | out_gnt[o];
      xbar_v_o[o]                     = out_v[o];
      xbar_sel_o[o*PORT_W +: PORT_W]  = out_idx[o];
    end
  end

  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (req_i[i]) begin
        if (!req_ok[i]) begin
          err_set = 1'b1;
        end else if (lock_v[dest[i]] && (lock_own[dest[i]] == PORT_W'(i))) begin
          if (head_i[i]) err_set = 1'b1;
        end else if (!head_i[i]) begin
          err_set = 1'b1;
        end
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      if (credit_i[o] && (cred[o] == CRED_W'(BUF_DEPTH)) && !out_v[o]) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_v <= '0;
      err_o  <= 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        lock_own[o] <= '0;
        rr_ptr[o]   <= '0;
        cred[o]     <= CRED_W'(BUF_DEPTH);
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (out_v[o]) begin
          if (!lock_v[o]) begin
            rr_ptr[o] <= (arb_idx[o] == PORT_W'(N_PORTS - 1)) ? '0 : arb_idx[o] + 1'b1;
            if (!tail_i[arb_idx[o]]) begin
              lock_v[o]   <= 1'b1;
              lock_own[o] <= arb_idx[o];
            end
          end else if (tail_i[lock_own[o]]) begin
            lock_v[o] <= 1'b0;
          end
        end
        // A returned credit with a full counter is a downstream bug; hold at max.
        if (out_v[o] && !credit_i[o]) begin
          cred[o] <= cred[o] - 1'b1;
        end else if (!out_v[o] && credit_i[o] && (cred[o] != CRED_W'(BUF_DEPTH))) begin
          cred[o] <= cred[o] + 1'b1;
        end
      end
      if (err_set) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator with hand-computed vectors.
// Inputs change 1ns after a rising edge; outputs are checked 4ns later.
module tb_switch_allocator;
  import noc_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_PORTS-1:0]        req;
  logic [N_PORTS-1:0]        head;
  logic [N_PORTS-1:0]        tail;
  logic [N_PORTS-1:0]        credit;
  logic [PORT_W-1:0]         dest [N_PORTS];
  logic [N_PORTS*PORT_W-1:0] req_dest;
  logic [N_PORTS-1:0]        grant;
  logic [N_PORTS-1:0]        xbar_v;
  logic [N_PORTS*PORT_W-1:0] xbar_sel;
  logic                      err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) req_dest[i*PORT_W +: PORT_W] = dest[i];
  end

  switch_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .req_dest_i (req_dest),
    .head_i     (head),
    .tail_i     (tail),
    .credit_i   (credit),
    .grant_o    (grant),
    .xbar_v_o   (xbar_v),
    .xbar_sel_o (xbar_sel),
    .err_o      (err)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    req    = '0;
    head   = '0;
    tail   = '0;
    credit = '0;
    for (int i = 0; i < N_PORTS; i++) dest[i] = '0;
  endtask

  task automatic set_flit(input int i, input int d, input logic h, input logic t);
    req[i]  = 1'b1;
    dest[i] = PORT_W'(d);
    head[i] = h;
    tail[i] = t;
  endtask

  // Check one cycle's combinational outputs, then advance to the next cycle.
  task automatic apply_stimulus(input string tag, input logic [N_PORTS-1:0] exp_grant,
                                input logic [N_PORTS-1:0] exp_v, input int sel_port, input int exp_sel);
    #4;
    check_output({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check_output({tag, ".xbar_v"}, 32'(xbar_v), 32'(exp_v));
    if (sel_port >= 0)
      check_output({tag, ".sel"}, 32'(xbar_sel[sel_port*PORT_W +: PORT_W]), 32'(exp_sel));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit g;
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset forces outputs low even with live requests.
    set_flit(0, EAST, 1'b1, 1'b1);
    set_flit(3, SOUTH, 1'b1, 1'b1);
    #4;
    check_output("rst.grant", 32'(grant), 32'h0);
    check_output("rst.xbar_v", 32'(xbar_v), 32'h0);
    check_output("rst.sel", 32'(xbar_sel), 32'h0);
    do_reset();
    check_output("rst.err", 32'(err), 32'h0);
    apply_stimulus("idle", 5'b00000, 5'b00000, -1, 0);

    // Round-robin between inputs 0 and 2 on output 1; credits returned each cycle.
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      set_flit(0, EAST, 1'b1, 1'b1);
      set_flit(2, EAST, 1'b1, 1'b1);
      credit[1] = 1'b1;
      apply_stimulus($sformatf("rr%0d", c), (c % 2 == 1) ? 5'b00100 : 5'b00001, 5'b00010, 1,
                     (c % 2 == 1) ? 2 : 0);
    end
    clear_inputs();
    set_flit(0, EAST, 1'b1, 1'b1);
    set_flit(4, EAST, 1'b1, 1'b1);
    credit[1] = 1'b1;
    apply_stimulus("rr_ptr3", 5'b10000, 5'b00010, 1, 4);
    check_output("rr.err", 32'(err), 32'h0);

    // Input 3 holds output 4 for a 3-flit packet while input 1 waits.
    do_reset();
    set_flit(3, LOCAL, 1'b1, 1'b0);
    apply_stimulus("lock.head", 5'b01000, 5'b10000, 4, 3);
    clear_inputs();
    set_flit(3, LOCAL, 1'b0, 1'b0);
    set_flit(1, LOCAL, 1'b1, 1'b1);
    apply_stimulus("lock.body", 5'b01000, 5'b10000, 4, 3);
    clear_inputs();
    set_flit(3, LOCAL, 1'b0, 1'b1);
    set_flit(1, LOCAL, 1'b1, 1'b1);
    apply_stimulus("lock.tail", 5'b01000, 5'b10000, 4, 3);
    clear_inputs();
    set_flit(1, LOCAL, 1'b1, 1'b1);
    apply_stimulus("lock.next", 5'b00010, 5'b10000, 4, 1);
    check_output("lock.err", 32'(err), 32'h0);

    // Credit stall: 6-flit packet from input 4 to output 0.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      g = (c <= 4) || (c == 7) || (c == 9);
      clear_inputs();
      set_flit(4, NORTH, c == 1, c == 9);
      credit[0] = (c == 6) || (c == 8);
      apply_stimulus($sformatf("cred.c%0d", c), g ? 5'b10000 : 5'b00000, g ? 5'b00001 : 5'b00000,
                     g ? 0 : -1, 4);
    end
    check_output("cred.err", 32'(err), 32'h0);

    // Grant plus credit at cred=2 leaves it at 2; then overflow sets err.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      clear_inputs();
      set_flit(0, SOUTH, 1'b1, 1'b1);
      credit[2] = (c == 3);
      apply_stimulus($sformatf("gc.c%0d", c), (c <= 5) ? 5'b00001 : 5'b00000,
                     (c <= 5) ? 5'b00100 : 5'b00000, -1, 0);
    end
    for (int c = 7; c <= 10; c++) begin
      clear_inputs();
      credit[2] = 1'b1;
      apply_stimulus($sformatf("gc.c%0d", c), 5'b00000, 5'b00000, -1, 0);
    end
    check_output("gc.err_before", 32'(err), 32'h0);
    clear_inputs();
    credit[2] = 1'b1;
    apply_stimulus("gc.overflow", 5'b00000, 5'b00000, -1, 0);
    check_output("gc.err_after", 32'(err), 32'h1);
    for (int c = 12; c <= 16; c++) begin
      clear_inputs();
      set_flit(0, SOUTH, 1'b1, 1'b1);
      apply_stimulus($sformatf("gc.c%0d", c), (c <= 15) ? 5'b00001 : 5'b00000,
                     (c <= 15) ? 5'b00100 : 5'b00000, -1, 0);
    end
    check_output("gc.err_sticky", 32'(err), 32'h1);

    // Reset mid-packet drops the lock on output 1.
    do_reset();
    check_output("mid.err_clr", 32'(err), 32'h0);
    set_flit(0, EAST, 1'b1, 1'b0);
    apply_stimulus("mid.head", 5'b00001, 5'b00010, 1, 0);
    clear_inputs();
    set_flit(0, EAST, 1'b0, 1'b0);
    apply_stimulus("mid.body", 5'b00001, 5'b00010, 1, 0);
    clear_inputs();
    set_flit(0, EAST, 1'b0, 1'b0);
    set_flit(2, EAST, 1'b1, 1'b1);
    rst = 1'b0;
    #4;
    check_output("mid.rst_grant", 32'(grant), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    set_flit(2, EAST, 1'b1, 1'b1);
    apply_stimulus("mid.after", 5'b00100, 5'b00010, 1, 2);
    check_output("mid.err", 32'(err), 32'h0);

    // Protocol errors: bad destination, orphan body flit, owner re-sending a head.
    do_reset();
    set_flit(0, 5, 1'b1, 1'b1);
    apply_stimulus("err.dest", 5'b00000, 5'b00000, -1, 0);
    check_output("err.dest_flag", 32'(err), 32'h1);
    do_reset();
    set_flit(2, WEST, 1'b0, 1'b1);
    apply_stimulus("err.orphan", 5'b00000, 5'b00000, -1, 0);
    check_output("err.orphan_flag", 32'(err), 32'h1);
    do_reset();
    set_flit(1, WEST, 1'b1, 1'b0);
    apply_stimulus("err.lockhd", 5'b00010, 5'b01000, 3, 1);
    check_output("err.lockhd_pre", 32'(err), 32'h0);
    clear_inputs();
    set_flit(1, WEST, 1'b1, 1'b1);
    apply_stimulus("err.rehead", 5'b00000, 5'b00000, -1, 0);
    check_output("err.rehead_flag", 32'(err), 32'h1);
    do_reset();
    head = '1;
    tail = 5'b10101;
    for (int i = 0; i < N_PORTS; i++) dest[i] = 3'd7;
    apply_stimulus("err.noreq", 5'b00000, 5'b00000, -1, 0);
    check_output("err.noreq_flag", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Output-port allocator for the 5-port wormhole router.
- Each cycle it grants crossbar paths from input buffers to output ports.
- Arbitration is round-robin per output; an output is locked to one input from head flit to tail flit.
- Per-output credit counters track free slots in the downstream buffer.
- Sits between the input buffer heads and the crossbar select lines. It replaces ad-hoc per-port arbitration with one sequenced scheduler.

Parameters:
- N_PORTS, 5, number of input and output ports (N, E, S, W, LOCAL).
- BUF_DEPTH, 4, downstream input-buffer depth in flits; credit counter reset value.
- PORT_W, $clog2(N_PORTS), width of a port index.
- CRED_W, $clog2(BUF_DEPTH+1), credit counter width.

Ports:
- clk  in  1  Clock; the single clock domain.
- rst  in  1  Reset; synchronous, active-low.
- req_i  in  N_PORTS  Input i has a flit at its buffer head.
- req_dest_i  in  N_PORTS*PORT_W  Destination output index per input; slice i belongs to input i.
- head_i  in  N_PORTS  Flit at input i is a head flit.
- tail_i  in  N_PORTS  Flit at input i is a tail flit. A single-flit packet has head=tail=1.
- credit_i  in  N_PORTS  Downstream of output o freed one slot this cycle.
- grant_o  out  N_PORTS  Input i's flit is transferred this cycle; the input pops its buffer.
- xbar_v_o  out  N_PORTS  Output o carries a valid flit this cycle.
- xbar_sel_o  out  N_PORTS*PORT_W  Input index driving output o.
- err_o  out  1  Sticky protocol-error flag.

Behaviour:
- State per output o:
  - lock_v[o] and lock_own[o] (PORT_W bits)
  - rr_ptr[o] (PORT_W bits)
  - cred[o] (CRED_W bits)
- Reset, synchronous while rst==0:
  - lock_v=0, lock_own=0, rr_ptr=0, cred=BUF_DEPTH, err_o=0.
  - grant_o, xbar_v_o and xbar_sel_o are forced to 0 in the same cycle.
  - Reset mid-packet drops all locks and restores full credits. Upstream and downstream reset together.
- Grant timing: grant_o, xbar_v_o and xbar_sel_o are combinational from registered state plus current inputs. A flit moves in the same cycle it is granted; latency 0. State updates on the next rising clk.
- An input requests exactly one output, so at most one grant per input per cycle. Each output grants at most one input.
- Output o is eligible only when cred[o] != 0. When cred[o]==0, no grant on o and no state change on o.
- Unlocked output (lock_v[o]==0):
  - Candidates are inputs with req_i=1, head_i=1 and dest==o.
  - Winner is the first candidate at or after rr_ptr[o], wrapping N_PORTS-1 -> 0.
  - On grant, rr_ptr[o] <= winner+1 mod N_PORTS.
  - If the winner's tail_i==0: lock_v[o]<=1, lock_own[o]<=winner.
  - A single-flit packet (head and tail both set) never locks.
- Locked output (lock_v[o]==1):
  - Only lock_own[o] is considered; its flit must have head_i=0 and dest==o. Grant it if credits allow.
  - On a granted flit with tail_i=1, lock_v[o]<=0; rr_ptr is unchanged.
  - Other inputs targeting o wait; no grant.
- Credits: each cycle cred[o] <= cred[o] - grant_on_o + credit_i[o].
  - Grant and credit in the same cycle leave the counter unchanged.
  - credit_i[o] with cred[o]==BUF_DEPTH and no grant: counter stays at BUF_DEPTH and err_o<=1.
- Other err_o causes, all sticky until reset:
  - The owner presents head_i=1 while locked; the flit is not granted.
  - A non-head flit requests an output not locked to that input; the flit is not granted.
  - req_dest_i >= N_PORTS; the request is ignored.
- Requests with req_i=0 are ignored regardless of head_i, tail_i or dest.

Decomposition:
- Package noc_pkg holds:
  - N_PORTS, PORT_W, BUF_DEPTH, CRED_W
  - port_e enum: NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4
- Sub-module rr_arbiter: N-way request vector plus pointer in, one-hot grant and index out, purely combinational. It is instantiated once per output inside a generate loop.
- Lock, pointer and credit registers live in switch_allocator.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> grant_o=0, xbar_v_o=0, err_o=0, all cred=4.
- Inputs 0 and 2 request output 1 with single-flit packets (head=tail=1), held for 4 cycles -> grants alternate 0,2,0,2; xbar_sel_o[1] follows the grant; rr_ptr[1] ends at 3.
- Input 3 sends a 3-flit packet to output 4 while input 1 requests output 4 with a head flit -> input 3 holds output 4 for 3 consecutive cycles; input 1 is granted in cycle 4.
- Output 0 with cred=4 and no credit_i, input 4 streams a 6-flit packet:
  - grants in cycles 1-4, then stall while cred=0;
  - credit_i[0] pulse in cycle 6 -> one grant in cycle 7.
- In the same cycle, a grant on output 2 and credit_i[2]=1 at cred=2 -> cred stays 2. Separately, credit_i[2] at cred=4 with no grant -> err_o=1, cred stays 4.
- Assert rst=0 mid-packet while output 1 is locked to input 0 -> next cycle lock cleared; a head flit from input 2 to output 1 is granted.
